// File: rtl/mem_wb_stage_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
// The master issues requests; the slave answers with ready and read data.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB register: branch redirect, byte/half/word data-memory access
// with wait-state stalling. Define DMEM_TIMEOUT_EN to abort accesses stuck in WAIT.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_EX,
    input  logic [1:0]            ResultSrc_EX,
    input  logic [1:0]            Mem_Con_EX,
    input  logic                  Branch_EX,
    input  logic                  PCSrc_EX,
    input  logic                  Zero_EX,
    input  logic [31:0]           PC_ALU_Sum_EX,
    input  logic [31:0]           ALUresult_EX,
    input  logic [31:0]           data2_EX,
    input  logic [2:0]            funct3_EX,
    input  logic [4:0]            rd_ID_EX_EX,
    input  logic [31:0]           PC_next_EX,
    mem_wb_stage_if.master        dmem,
    output logic                  stall_mem,
    output logic                  PCSrc_MEM,
    output logic [31:0]           PC_target_MEM,
    output logic                  RegWrite_WB,
    output logic [1:0]            ResultSrc_WB,
    output logic [31:0]           ALUresult_WB,
    output logic [31:0]           ReadData_WB,
    output logic [31:0]           PC_next_WB,
    output logic [4:0]            rd_WB,
    output logic                  misalign_WB
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [1:0]  byte_off;
    logic        is_load, is_store, mem_op, misaligned, misaligned_op, access_valid;
    logic        in_wait, req, timeout_hit;
    logic [31:0] st_wdata, load_data;
    logic [3:0]  st_be;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign byte_off      = ALUresult_EX[1:0];
    assign is_load       = (Mem_Con_EX == 2'b01);
    assign is_store      = (Mem_Con_EX == 2'b10);
    assign mem_op        = is_load | is_store;
    assign misaligned    = (funct3_EX[1:0] == 2'b00) ? 1'b0 :
                           (funct3_EX[1:0] == 2'b01) ? byte_off[0] : (byte_off != 2'b00);
    assign misaligned_op = mem_op & misaligned;
    assign access_valid  = mem_op & ~misaligned;
    assign in_wait       = (state == WAIT);

    // Every combinational output is forced low while reset is held.
    assign req              = rst & (in_wait | access_valid);
    assign stall_mem        = req & ~dmem.dmem_ready & ~timeout_hit;
    assign dmem.dmem_req    = req;
    assign dmem.dmem_we     = req & is_store;
    assign dmem.dmem_addr   = rst ? {ALUresult_EX[31:2], 2'b00} : 32'h0;
    assign dmem.dmem_wdata  = rst ? st_wdata : 32'h0;
    assign dmem.dmem_be     = rst ? st_be : 4'h0;
    assign PCSrc_MEM        = rst & (PCSrc_EX | (Branch_EX & Zero_EX));
    assign PC_target_MEM    = rst ? PC_ALU_Sum_EX : 32'h0;

    always_comb begin
        st_wdata = data2_EX;
        st_be    = 4'b1111;
        if (is_store) begin
            case (funct3_EX[1:0])
                2'b00: begin
                    st_wdata = {4{data2_EX[7:0]}};
                    st_be    = 4'b0001 << byte_off;
                end
                2'b01: begin
                    st_wdata = {2{data2_EX[15:0]}};
                    st_be    = 4'b0011 << byte_off;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (byte_off)
            2'b00:   rd_byte = dmem.dmem_rdata[7:0];
            2'b01:   rd_byte = dmem.dmem_rdata[15:8];
            2'b10:   rd_byte = dmem.dmem_rdata[23:16];
            default: rd_byte = dmem.dmem_rdata[31:24];
        endcase
        rd_half = byte_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_EX)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = in_wait & ~dmem.dmem_ready &
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero in IDLE so each WAIT episode starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (!in_wait)
            wait_cnt <= '0;
        else if (!dmem.dmem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // A stalled edge loads a bubble so the held instruction is written back only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            RegWrite_WB  <= 1'b0;
            ResultSrc_WB <= 2'b00;
            ALUresult_WB <= 32'h0;
            ReadData_WB  <= 32'h0;
            PC_next_WB   <= 32'h0;
            rd_WB        <= 5'd0;
            misalign_WB  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (access_valid && !dmem.dmem_ready)
                    state <= WAIT;
            end else if (dmem.dmem_ready || timeout_hit) begin
                state <= IDLE;
            end

            if (stall_mem) begin
                RegWrite_WB  <= 1'b0;
                ResultSrc_WB <= 2'b00;
                ALUresult_WB <= 32'h0;
                ReadData_WB  <= 32'h0;
                PC_next_WB   <= 32'h0;
                rd_WB        <= 5'd0;
                misalign_WB  <= 1'b0;
            end else begin
                RegWrite_WB  <= RegWrite_EX & ~is_store & ~misaligned_op & ~timeout_hit;
                ResultSrc_WB <= ResultSrc_EX;
                ALUresult_WB <= ALUresult_EX;
                ReadData_WB  <= (is_load && req && dmem.dmem_ready) ? load_data : 32'h0;
                PC_next_WB   <= PC_next_EX;
                rd_WB        <= rd_ID_EX_EX;
                misalign_WB  <= misaligned_op | timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; the abort scenario is exercised
// only when DMEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_EX;
    logic [1:0]  ResultSrc_EX;
    logic [1:0]  Mem_Con_EX;
    logic        Branch_EX;
    logic        PCSrc_EX;
    logic        Zero_EX;
    logic [31:0] PC_ALU_Sum_EX;
    logic [31:0] ALUresult_EX;
    logic [31:0] data2_EX;
    logic [2:0]  funct3_EX;
    logic [4:0]  rd_ID_EX_EX;
    logic [31:0] PC_next_EX;
    logic        stall_mem;
    logic        PCSrc_MEM;
    logic [31:0] PC_target_MEM;
    logic        RegWrite_WB;
    logic [1:0]  ResultSrc_WB;
    logic [31:0] ALUresult_WB;
    logic [31:0] ReadData_WB;
    logic [31:0] PC_next_WB;
    logic [4:0]  rd_WB;
    logic        misalign_WB;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mem_wb_stage_if dmem_bus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite_EX   (RegWrite_EX),
        .ResultSrc_EX  (ResultSrc_EX),
        .Mem_Con_EX    (Mem_Con_EX),
        .Branch_EX     (Branch_EX),
        .PCSrc_EX      (PCSrc_EX),
        .Zero_EX       (Zero_EX),
        .PC_ALU_Sum_EX (PC_ALU_Sum_EX),
        .ALUresult_EX  (ALUresult_EX),
        .data2_EX      (data2_EX),
        .funct3_EX     (funct3_EX),
        .rd_ID_EX_EX   (rd_ID_EX_EX),
        .PC_next_EX    (PC_next_EX),
        .dmem          (dmem_bus.master),
        .stall_mem     (stall_mem),
        .PCSrc_MEM     (PCSrc_MEM),
        .PC_target_MEM (PC_target_MEM),
        .RegWrite_WB   (RegWrite_WB),
        .ResultSrc_WB  (ResultSrc_WB),
        .ALUresult_WB  (ALUresult_WB),
        .ReadData_WB   (ReadData_WB),
        .PC_next_WB    (PC_next_WB),
        .rd_WB         (rd_WB),
        .misalign_WB   (misalign_WB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        RegWrite_EX   = 1'b0;
        ResultSrc_EX  = 2'b00;
        Mem_Con_EX    = 2'b00;
        Branch_EX     = 1'b0;
        PCSrc_EX      = 1'b0;
        Zero_EX       = 1'b0;
        PC_ALU_Sum_EX = 32'h0;
        ALUresult_EX  = 32'h0;
        data2_EX      = 32'h0;
        funct3_EX     = 3'b000;
        rd_ID_EX_EX   = 5'd0;
        PC_next_EX    = 32'h0;
    endtask

    task automatic applyStimulus(input logic [1:0] memCon, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] storeData,
                                 input logic regWr, input logic [1:0] resSrc,
                                 input logic [4:0] rd);
        Mem_Con_EX   = memCon;
        funct3_EX    = f3;
        ALUresult_EX = addr;
        data2_EX     = storeData;
        RegWrite_EX  = regWr;
        ResultSrc_EX = resSrc;
        rd_ID_EX_EX  = rd;
    endtask

    // Byte load at 0x103 with three wait states; memory word 0x80112233.
    task automatic doWaitedLoad(input logic [2:0] f3, input logic [31:0] expData);
        applyStimulus(2'b01, f3, 32'h103, 32'h0, 1'b1, 2'b01, 5'd9);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h80112233;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("wait_stall", stall_mem, 1'b1);
            checkOutput("wait_req", dmem_bus.dmem_req, 1'b1);
            @(negedge clk);
            checkOutput("bubble_regwrite", RegWrite_WB, 1'b0);
            checkOutput("bubble_rd", rd_WB, 5'd0);
        end
        dmem_bus.dmem_ready = 1'b1;
        #1 checkOutput("ready_no_stall", stall_mem, 1'b0);
        @(negedge clk);
        checkOutput("waited_load_data", ReadData_WB, expData);
        checkOutput("waited_load_regwrite", RegWrite_WB, 1'b1);
        checkOutput("waited_load_rd", rd_WB, 5'd9);
        dmem_bus.dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clearInputs();
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h0;
        // Live-looking inputs during reset must not leak onto any output.
        applyStimulus(2'b01, 3'b010, 32'h100, 32'h0, 1'b1, 2'b01, 5'd3);
        PCSrc_EX = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkOutput("rst_req", dmem_bus.dmem_req, 1'b0);
        checkOutput("rst_stall", stall_mem, 1'b0);
        checkOutput("rst_pcsrc", PCSrc_MEM, 1'b0);
        checkOutput("rst_be", dmem_bus.dmem_be, 4'h0);
        checkOutput("rst_regwrite", RegWrite_WB, 1'b0);
        checkOutput("rst_readdata", ReadData_WB, 32'h0);
        checkOutput("rst_misalign", misalign_WB, 1'b0);
        clearInputs();
        dmem_bus.dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait LW
        applyStimulus(2'b01, 3'b010, 32'h100, 32'h0, 1'b1, 2'b01, 5'd5);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEADBEEF;
        #1 checkOutput("lw_req", dmem_bus.dmem_req, 1'b1);
        checkOutput("lw_stall", stall_mem, 1'b0);
        checkOutput("lw_we", dmem_bus.dmem_we, 1'b0);
        checkOutput("lw_be", dmem_bus.dmem_be, 4'b1111);
        checkOutput("lw_addr", dmem_bus.dmem_addr, 32'h100);
        @(negedge clk);
        checkOutput("lw_data", ReadData_WB, 32'hDEADBEEF);
        checkOutput("lw_regwrite", RegWrite_WB, 1'b1);
        checkOutput("lw_rd", rd_WB, 5'd5);

        // Back-to-back waited LB then LBU
        doWaitedLoad(3'b000, 32'hFFFFFF80);
        doWaitedLoad(3'b100, 32'h00000080);

        // SH at 0x202
        applyStimulus(2'b10, 3'b001, 32'h202, 32'h0000ABCD, 1'b0, 2'b00, 5'd0);
        dmem_bus.dmem_ready = 1'b1;
        #1 checkOutput("sh_be", dmem_bus.dmem_be, 4'b1100);
        checkOutput("sh_wdata", dmem_bus.dmem_wdata, 32'hABCDABCD);
        checkOutput("sh_we", dmem_bus.dmem_we, 1'b1);
        checkOutput("sh_addr", dmem_bus.dmem_addr, 32'h200);
        @(negedge clk);
        checkOutput("sh_regwrite", RegWrite_WB, 1'b0);
        checkOutput("sh_misalign", misalign_WB, 1'b0);

        // SB at 0x201
        applyStimulus(2'b10, 3'b000, 32'h201, 32'h12345678, 1'b0, 2'b00, 5'd0);
        #1 checkOutput("sb_be", dmem_bus.dmem_be, 4'b0010);
        checkOutput("sb_wdata", dmem_bus.dmem_wdata, 32'h78787878);
        @(negedge clk);

        // Misaligned LW at 0x101
        applyStimulus(2'b01, 3'b010, 32'h101, 32'h0, 1'b1, 2'b01, 5'd6);
        dmem_bus.dmem_ready = 1'b0;
        #1 checkOutput("mis_req", dmem_bus.dmem_req, 1'b0);
        checkOutput("mis_stall", stall_mem, 1'b0);
        @(negedge clk);
        checkOutput("mis_flag", misalign_WB, 1'b1);
        checkOutput("mis_regwrite", RegWrite_WB, 1'b0);

        // Non-memory pass-through
        applyStimulus(2'b00, 3'b000, 32'h1234, 32'h0, 1'b1, 2'b00, 5'd7);
        PC_next_EX = 32'h44;
        #1 checkOutput("alu_req", dmem_bus.dmem_req, 1'b0);
        @(negedge clk);
        checkOutput("alu_regwrite", RegWrite_WB, 1'b1);
        checkOutput("alu_result", ALUresult_WB, 32'h1234);
        checkOutput("alu_readdata", ReadData_WB, 32'h0);
        checkOutput("alu_misalign", misalign_WB, 1'b0);
        checkOutput("alu_pcnext", PC_next_WB, 32'h44);
        checkOutput("alu_rd", rd_WB, 5'd7);

        // Branch redirect
        clearInputs();
        Branch_EX = 1'b1;
        Zero_EX = 1'b1;
        PC_ALU_Sum_EX = 32'h40;
        #1 checkOutput("br_taken", PCSrc_MEM, 1'b1);
        checkOutput("br_target", PC_target_MEM, 32'h40);
        Zero_EX = 1'b0;
        #1 checkOutput("br_not_taken", PCSrc_MEM, 1'b0);
        clearInputs();
        @(negedge clk);

        // Reset while in WAIT, then a late ready
        applyStimulus(2'b01, 3'b010, 32'h300, 32'h0, 1'b1, 2'b01, 5'd8);
        dmem_bus.dmem_ready = 1'b0;
        @(negedge clk);
        #1 checkOutput("wait_before_rst", stall_mem, 1'b1);
        rst = 1'b0;
        #1 checkOutput("rst_wait_req", dmem_bus.dmem_req, 1'b0);
        checkOutput("rst_wait_stall", stall_mem, 1'b0);
        clearInputs();
        dmem_bus.dmem_ready = 1'b1;
        #1 checkOutput("rst_ready_req", dmem_bus.dmem_req, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("post_rst_req", dmem_bus.dmem_req, 1'b0);
        checkOutput("post_rst_stall", stall_mem, 1'b0);
        @(negedge clk);
        dmem_bus.dmem_ready = 1'b0;
        checkOutput("post_rst_regwrite", RegWrite_WB, 1'b0);
        checkOutput("post_rst_readdata", ReadData_WB, 32'h0);
        checkOutput("post_rst_misalign", misalign_WB, 1'b0);
        checkOutput("post_rst_rd", rd_WB, 5'd0);

`ifdef DMEM_TIMEOUT_EN
        // Memory never answers: abort on the 15th WAIT cycle.
        applyStimulus(2'b01, 3'b010, 32'h400, 32'h0, 1'b1, 2'b01, 5'd10);
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            #1 checkOutput("to_stall", stall_mem, 1'b1);
            @(negedge clk);
        end
        #1 checkOutput("to_abort_stall", stall_mem, 1'b0);
        @(negedge clk);
        clearInputs();
        #1 checkOutput("to_req_dropped", dmem_bus.dmem_req, 1'b0);
        checkOutput("to_misalign", misalign_WB, 1'b1);
        checkOutput("to_regwrite", RegWrite_WB, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
